// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one byte at a time from NUM_REQ requesters to a UART transmitter.
// A watchdog aborts frames the transmitter never completes, and an idle gap separates frames.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 16,
  parameter int TIMEOUT_CLKS = 20000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [8*NUM_REQ-1:0]   i_req_byte,
  output logic [NUM_REQ-1:0]     o_ack,
  output logic                   o_tx_dv,
  output logic [7:0]             o_tx_byte,
  input  logic                   i_tx_active,
  input  logic                   i_tx_done,
  output logic                   o_busy,
  output logic [2:0]             o_grant_id,
  output logic                   o_err_timeout
);

  localparam int GAP_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CLKS - 1);
  localparam logic [2:0]       LAST_REQ = 3'(NUM_REQ - 1);

  typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, WAIT_DONE, GAP} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tx_dv_q, tx_dv_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               busy_q, busy_d;
  logic [2:0]         grant_q, grant_d;
  logic               err_q, err_d;
  logic [2:0]         last_grant_q, last_grant_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [WD_W-1:0]    wd_q, wd_d;

  logic [2:0] win_id, lo_id;
  logic [7:0] win_byte, lo_byte;
  logic       found_hi, found_lo;
  logic [WD_W-1:0] wd_next;

  // First requester above last_grant wins; otherwise wrap to the lowest requester.
  always_comb begin
    win_id   = '0;
    win_byte = '0;
    lo_id    = '0;
    lo_byte  = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_req[k] && !found_lo) begin
        found_lo = 1'b1;
        lo_id    = 3'(k);
        lo_byte  = i_req_byte[8*k +: 8];
      end
      if (i_req[k] && !found_hi && (3'(k) > last_grant_q)) begin
        found_hi = 1'b1;
        win_id   = 3'(k);
        win_byte = i_req_byte[8*k +: 8];
      end
    end
    if (!found_hi) begin
      win_id   = lo_id;
      win_byte = lo_byte;
    end
  end

  always_comb begin
    state_d      = state_q;
    ack_d        = '0;
    tx_dv_d      = 1'b0;
    tx_byte_d    = tx_byte_q;
    grant_d      = grant_q;
    err_d        = 1'b0;
    last_grant_d = last_grant_q;
    gap_d        = gap_q;
    wd_d         = wd_q;
    wd_next      = wd_q + WD_W'(1);
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          ack_d        = NUM_REQ'(1) << win_id;
          tx_byte_d    = win_byte;
          grant_d      = win_id;
          last_grant_d = win_id;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        if (!i_tx_active) begin
          tx_dv_d = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        wd_d = wd_next;
        // Done has priority over a timeout landing in the same cycle.
        if (i_tx_done) begin
          gap_d   = '0;
          state_d = GAP;
        end else if (wd_next == WD_LAST) begin
          err_d   = 1'b1;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      ack_q        <= '0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= 8'h00;
      busy_q       <= 1'b0;
      grant_q      <= '0;
      err_q        <= 1'b0;
      last_grant_q <= LAST_REQ;
      gap_q        <= '0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      tx_dv_q      <= tx_dv_d;
      tx_byte_q    <= tx_byte_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
      gap_q        <= gap_d;
      wd_q         <= wd_d;
    end
  end

  assign o_ack         = ack_q;
  assign o_tx_dv       = tx_dv_q;
  assign o_tx_byte     = tx_byte_q;
  assign o_busy        = busy_q;
  assign o_grant_id    = grant_q;
  assign o_err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter against a transaction-level reference model.
// A second small instance covers the zero-gap, done-versus-timeout boundary.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int GAP   = 4;
  localparam int TMO   = 50;
  localparam int B_TMO = 8;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [N-1:0]   i_req;
  logic [8*N-1:0] i_req_byte;
  logic [N-1:0]   o_ack;
  logic           o_tx_dv;
  logic [7:0]     o_tx_byte;
  logic           i_tx_active;
  logic           i_tx_done;
  logic           o_busy;
  logic [2:0]     o_grant_id;
  logic           o_err_timeout;

  logic           b_rst;
  logic [1:0]     b_req;
  logic [15:0]    b_req_byte;
  logic [1:0]     b_ack;
  logic           b_tx_dv;
  logic [7:0]     b_tx_byte;
  logic           b_tx_active;
  logic           b_tx_done;
  logic           b_busy;
  logic [2:0]     b_grant;
  logic           b_err;

  int checks = 0;
  int passed = 0;
  int excl_viol = 0;

  int           last_grant;
  logic [N-1:0] pending;
  logic [7:0]   bytes [N];

  always #5 i_clk = ~i_clk;

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_req_byte(i_req_byte),
    .o_ack(o_ack), .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte),
    .i_tx_active(i_tx_active), .i_tx_done(i_tx_done), .o_busy(o_busy),
    .o_grant_id(o_grant_id), .o_err_timeout(o_err_timeout)
  );

  uart_tx_arbiter #(.NUM_REQ(2), .GAP_CLKS(0), .TIMEOUT_CLKS(B_TMO)) dut_b (
    .i_clk(i_clk), .i_rst(b_rst), .i_req(b_req), .i_req_byte(b_req_byte),
    .o_ack(b_ack), .o_tx_dv(b_tx_dv), .o_tx_byte(b_tx_byte),
    .i_tx_active(b_tx_active), .i_tx_done(b_tx_done), .o_busy(b_busy),
    .o_grant_id(b_grant), .o_err_timeout(b_err)
  );

  // At most one ack per cycle, and never together with a launch.
  always @(negedge i_clk) begin
    if (!i_rst && (($countones(o_ack) > 1) || ((o_ack != 0) && o_tx_dv)))
      excl_viol++;
  end

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int rrWinner(input int last, input logic [N-1:0] mask);
    for (int i = 1; i <= N; i++)
      if (mask[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic raiseReq(input int k);
    pending[k] = 1'b1;
    bytes[k]   = 8'($urandom);
  endtask

  task automatic applyStimulus(input logic [N-1:0] extra);
    i_req = pending | extra;
    for (int k = 0; k < N; k++) i_req_byte[8*k +: 8] = bytes[k];
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ack"}, o_ack, 0);
    checkOutput({tag, "_dv"}, o_tx_dv, 0);
    checkOutput({tag, "_byte"}, o_tx_byte, 0);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_grant"}, o_grant_id, 0);
    checkOutput({tag, "_err"}, o_err_timeout, 0);
  endtask

  // One frame from the IDLE decision cycle back to IDLE. done_k=0 means the transmitter never
  // finishes; mode 0 adds nothing, 1 re-raises the winner, 2 adds random and transient requests.
  task automatic runFrame(input int busy_cycles, input int done_k, input int mode);
    int           w, g, err_at, bad, tk;
    logic [7:0]   wbyte;
    logic [N-1:0] transient;
    transient = '0;
    if (pending == 0) raiseReq($urandom_range(N - 1));
    applyStimulus('0);
    w = rrWinner(last_grant, pending);
    wbyte = bytes[w];
    tick;
    checkOutput("ack", o_ack, 1 << w);
    checkOutput("grant_id", o_grant_id, w);
    checkOutput("capture_byte", o_tx_byte, wbyte);
    checkOutput("busy_load", o_busy, 1);
    last_grant = w;
    pending[w] = 1'b0;
    if (mode == 1) raiseReq(w);
    else if (mode == 2) begin
      for (int k = 0; k < N; k++)
        if (!pending[k] && $urandom_range(2) == 0) raiseReq(k);
      tk = $urandom_range(N - 1);
      if (!pending[tk]) transient[tk] = 1'b1;
    end
    applyStimulus(transient);

    bad = 0;
    i_tx_active = (busy_cycles > 0);
    for (int i = 0; i < busy_cycles; i++) begin
      i_tx_done = (i == 0);
      tick;
      if (o_tx_dv || (o_ack != 0) || !o_busy) bad++;
    end
    i_tx_active = 1'b0;
    i_tx_done   = 1'b0;
    if (busy_cycles > 0) checkOutput("hold_while_active", bad, 0);
    tick;
    checkOutput("launch_dv", o_tx_dv, 1);
    checkOutput("launch_byte", o_tx_byte, wbyte);

    g      = (done_k != 0) ? done_k + 1 : TMO;
    err_at = 0;
    bad    = 0;
    for (int t = 1; t <= g; t++) begin
      tick;
      i_tx_done = (t == done_k);
      if (o_err_timeout && err_at == 0) err_at = t;
      if (o_tx_dv) bad++;
    end
    checkOutput("err_timeout_cycle", err_at, (done_k == 0) ? TMO : 0);
    checkOutput("single_launch", bad, 0);
    checkOutput("busy_gap_start", o_busy, 1);

    bad = 0;
    i_tx_done = 1'($urandom_range(1));
    for (int j = 0; j < GAP; j++) begin
      tick;
      i_tx_done = 1'b0;
      if (!o_busy || o_err_timeout || (o_ack != 0)) bad++;
    end
    i_tx_done = 1'b0;
    checkOutput("gap_busy", bad, 0);
    tick;
    checkOutput("idle_after_gap", o_busy, 0);
    checkOutput("grant_hold", o_grant_id, w);
  endtask

  task automatic resetMidFrame();
    int w;
    if (pending == 0) raiseReq(0);
    applyStimulus('0);
    w = rrWinner(last_grant, pending);
    tick;
    checkOutput("rst_ack", o_ack, 1 << w);
    pending[w] = 1'b0;
    applyStimulus('0);
    tick;
    checkOutput("rst_launch", o_tx_dv, 1);
    repeat (5) tick;
    i_rst = 1'b1;
    i_req = '0;
    pending = '0;
    tick;
    i_rst = 1'b0;
    checkReset("mid_rst");
    i_tx_done = 1'b1;
    tick;
    i_tx_done = 1'b0;
    tick;
    checkOutput("stray_done_busy", o_busy, 0);
    checkOutput("stray_done_err", o_err_timeout, 0);
    last_grant = N - 1;
    for (int k = 0; k < N; k++) raiseReq(k);
    runFrame(0, 6, 0);
  endtask

  task automatic boundaryGap0();
    int err_seen;
    err_seen   = 0;
    b_req      = 2'b01;
    b_req_byte = 16'h003C;
    tick;
    checkOutput("b_ack", b_ack, 1);
    checkOutput("b_byte", b_tx_byte, 8'h3C);
    b_req = '0;
    tick;
    checkOutput("b_launch", b_tx_dv, 1);
    for (int t = 1; t < B_TMO; t++) begin
      tick;
      b_tx_done = (t == B_TMO - 1);
      if (b_err) err_seen++;
    end
    tick;
    b_tx_done = 1'b0;
    if (b_err) err_seen++;
    checkOutput("b_busy_gap", b_busy, 1);
    tick;
    if (b_err) err_seen++;
    checkOutput("b_idle_2_after_done", b_busy, 0);
    checkOutput("b_no_timeout_err", err_seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] stopped");
  end

  initial begin
    i_rst = 1'b1; i_req = '0; i_req_byte = '0; i_tx_active = 1'b0; i_tx_done = 1'b0;
    b_rst = 1'b1; b_req = '0; b_req_byte = '0; b_tx_active = 1'b0; b_tx_done = 1'b0;
    pending = '0;
    last_grant = N - 1;
    for (int k = 0; k < N; k++) bytes[k] = 8'h00;
    repeat (3) tick;
    i_rst = 1'b0;
    b_rst = 1'b0;
    checkReset("por");
    checkOutput("b_por_busy", b_busy, 0);

    boundaryGap0();

    for (int k = 0; k < N; k++) raiseReq(k);
    repeat (5) runFrame(0, 10, 1);

    pending  = 4'b0100;
    bytes[2] = 8'hA5;
    runFrame(0, 10, 0);

    raiseReq(1);
    runFrame(30, 10, 0);

    raiseReq(3);
    raiseReq(0);
    runFrame(0, 0, 0);
    runFrame(0, 7, 0);

    resetMidFrame();

    repeat (25)
      runFrame(($urandom_range(3) == 0) ? $urandom_range(1, 6) : 0,
               ($urandom_range(4) == 0) ? 0 : $urandom_range(1, TMO - 1), 2);

    checkOutput("ack_exclusive", excl_viol, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
